// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_types_pkg : shared word type, data-memory FSM states, alignment mask
// Revision      : 1.0
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } dmem_state_t;

  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic word_t word_align(input word_t addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stall_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stall_counter : saturating up-counter with enable and synchronous clear
// Revision      : 1.0
// ---------------------------------------------------------------------------
module stall_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_req_ctrl : MEM-stage dcache request controller driving the MEM/WB latch
// Revision      : 1.0
// ---------------------------------------------------------------------------
module dmem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              memValid,
  input  logic              memMemRead,
  input  logic              memMemWrite,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [ADDR_W-1:0] memstore,
  input  logic              memcuHALT,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmemstore,
  output logic [ADDR_W-1:0] memdmemload,
  output logic              memW,
  output logic              memRST,
  output logic              memStall,
  output logic              halted,
  output logic              misalignErr,
  output logic [CNT_W-1:0]  stallCnt
);

  dmem_state_t       state_q, state_d;
  logic              halted_q, halted_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] load_q, load_d;

  logic req;
  logic cnt_en;
  logic w_op;
  logic w_mis;
  logic w_halt;

  assign w_op   = memValid & (memMemRead | memMemWrite);
  assign w_mis  = w_op & (memaddr[1:0] != 2'b00);
  assign w_halt = memValid & memcuHALT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      load_q     <= load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    misalign_d  = misalign_q;
    load_d      = load_q;
    req         = 1'b0;
    cnt_en      = 1'b0;
    memW        = 1'b0;
    memRST      = 1'b0;
    memStall    = 1'b0;
    memdmemload = '0;

    // Everything combinational is forced low while reset is held.
    if (!RST) begin
      memdmemload = load_q;
      case (state_q)
        IDLE: begin
          // A halt outranks any memory op that shows up alongside it.
          if (w_halt) begin
            memW     = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (w_mis) begin
            memRST     = 1'b1;
            misalign_d = 1'b1;
          end else if (w_op) begin
            req = 1'b1;
            if (dhit) begin
              memW        = 1'b1;
              memdmemload = dmemload;
            end else begin
              memStall = 1'b1;
              state_d  = WAIT;
            end
          end else begin
            memW = 1'b1;
          end
        end
        WAIT: begin
          req    = 1'b1;
          cnt_en = 1'b1;
          if (dhit) begin
            memW        = 1'b1;
            memdmemload = dmemload;
            load_d      = dmemload;
            state_d     = IDLE;
          end else begin
            memStall = 1'b1;
          end
        end
        HALT: begin
          memStall = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Read wins when both request flags are set.
  assign dmemREN     = req & memMemRead;
  assign dmemWEN     = req & memMemWrite & ~memMemRead;
  assign dmemaddr    = req ? {memaddr[ADDR_W-1:2], 2'b00} : '0;
  assign dmemstore   = req ? memstore : '0;
  assign halted      = halted_q;
  assign misalignErr = misalign_q;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .CLK   (CLK),
    .RST   (RST),
    .en_i  (cnt_en),
    .clr_i (1'b0),
    .cnt_o (stallCnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_req_ctrl : vector table, corner sequences and randomized model check
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_dmem_req_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        memValid, memMemRead, memMemWrite, memcuHALT, dhit;
  logic [31:0] memaddr, memstore, dmemload;
  logic        dmemREN, dmemWEN, memW, memRST, memStall, halted, misalignErr;
  logic [31:0] dmemaddr, dmemstore, memdmemload;
  logic [15:0] stallCnt;

  always #5 CLK = ~CLK;

  dmem_req_ctrl #(.CNT_W(16), .ADDR_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .memValid    (memValid),
    .memMemRead  (memMemRead),
    .memMemWrite (memMemWrite),
    .memaddr     (memaddr),
    .memstore    (memstore),
    .memcuHALT   (memcuHALT),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .memdmemload (memdmemload),
    .memW        (memW),
    .memRST      (memRST),
    .memStall    (memStall),
    .halted      (halted),
    .misalignErr (misalignErr),
    .stallCnt    (stallCnt)
  );

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] ml;
    logic        mw;
    logic        mrst;
    logic        st;
    logic        hl;
    logic        me;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic        v, r, w, h, hit;
    logic [31:0] a, s, dl;
    obs_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic obs_t ex(input logic ren, wen, input logic [31:0] da, ds, ml,
                              input logic mw, mrst, st, hl, me, input logic [15:0] cnt);
    obs_t o;
    o = '{ren, wen, da, ds, ml, mw, mrst, st, hl, me, cnt};
    return o;
  endfunction

  function automatic vec_t mk(input logic v, r, w, h, hit,
                              input logic [31:0] a, s, dl, input obs_t e);
    vec_t x;
    x.v = v; x.r = r; x.w = w; x.h = h; x.hit = hit;
    x.a = a; x.s = s; x.dl = dl; x.e = e;
    return x;
  endfunction

  task automatic drive(input logic v, r, w, h, hit, input logic [31:0] a, s, dl);
    memValid = v; memMemRead = r; memMemWrite = w; memcuHALT = h; dhit = hit;
    memaddr = a; memstore = s; dmemload = dl;
  endtask

  task automatic check(input string name, input obs_t e);
    obs_t act;
    act = '{dmemREN, dmemWEN, dmemaddr, dmemstore, memdmemload, memW, memRST,
            memStall, halted, misalignErr, stallCnt};
    // Address/data buses only carry meaning while a request is up.
    if (!(e.ren | e.wen)) begin
      act.da = '0;
      act.ds = '0;
    end
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    RST = 1'b0;
  endtask

  vec_t vt[14];

  // Reference model state for the randomized phase
  bit          h_m, p_m, me_m;
  int          cnt_m;
  logic [31:0] ld_m;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0,0,0,0,0, 32'h0,       32'h0,        32'h0,        ex(0,0,0,0,0, 1,0,0,0,0,0));
    vt[1]  = mk(1,1,0,0,1, 32'h100,     32'h0,        32'hDEADBEEF, ex(1,0,32'h100,0,32'hDEADBEEF, 1,0,0,0,0,0));
    vt[2]  = mk(1,0,1,0,0, 32'h204,     32'h12345678, 32'h0,        ex(0,1,32'h204,32'h12345678,0, 0,0,1,0,0,0));
    vt[3]  = mk(1,0,1,0,0, 32'h204,     32'h12345678, 32'h0,        ex(0,1,32'h204,32'h12345678,0, 0,0,1,0,0,0));
    vt[4]  = mk(1,0,1,0,0, 32'h204,     32'h12345678, 32'h0,        ex(0,1,32'h204,32'h12345678,0, 0,0,1,0,0,1));
    vt[5]  = mk(1,0,1,0,1, 32'h204,     32'h12345678, 32'hCAFE0000, ex(0,1,32'h204,32'h12345678,32'hCAFE0000, 1,0,0,0,0,2));
    vt[6]  = mk(0,0,0,0,0, 32'h0,       32'h0,        32'h0,        ex(0,0,0,0,32'hCAFE0000, 1,0,0,0,0,3));
    vt[7]  = mk(1,0,0,0,1, 32'h0,       32'h0,        32'h99,       ex(0,0,0,0,32'hCAFE0000, 1,0,0,0,0,3));
    vt[8]  = mk(1,1,0,0,0, 32'h102,     32'h0,        32'h0,        ex(0,0,0,0,32'hCAFE0000, 0,1,0,0,0,3));
    vt[9]  = mk(1,1,0,0,1, 32'h300,     32'h0,        32'h11,       ex(1,0,32'h300,0,32'h11, 1,0,0,0,1,3));
    vt[10] = mk(1,1,1,0,1, 32'h310,     32'h55,       32'h33,       ex(1,0,32'h310,32'h55,32'h33, 1,0,0,0,1,3));
    vt[11] = mk(1,0,0,1,0, 32'h0,       32'h0,        32'h0,        ex(0,0,0,0,32'hCAFE0000, 1,0,0,0,1,3));
    vt[12] = mk(1,1,0,0,1, 32'h400,     32'h0,        32'h22,       ex(0,0,0,0,32'hCAFE0000, 0,0,1,1,1,3));
    vt[13] = mk(1,1,0,0,1, 32'h400,     32'h0,        32'h22,       ex(0,0,0,0,32'hCAFE0000, 0,0,1,1,1,3));

    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    #2 check("reset_state", '0);
    RST = 1'b0;
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].v, vt[i].r, vt[i].w, vt[i].h, vt[i].hit, vt[i].a, vt[i].s, vt[i].dl);
      #2 check($sformatf("vec%0d", i), vt[i].e);
      next_cycle();
    end

    // Reset asserted while a miss is outstanding
    reset_pulse();
    drive(1, 1, 0, 0, 0, 32'h500, 32'h0, 32'h0);
    #2 check("rst_wait_c1", ex(1,0,32'h500,0,0, 0,0,1,0,0,0));
    next_cycle();
    #2 check("rst_wait_c2", ex(1,0,32'h500,0,0, 0,0,1,0,0,0));
    RST = 1'b1;
    #1 check("rst_wait_drop", '0);
    next_cycle();
    RST = 1'b0;
    drive(1, 1, 0, 0, 1, 32'h600, 32'h0, 32'hAB);
    #2 check("rst_wait_after", ex(1,0,32'h600,0,32'hAB, 1,0,0,0,0,0));
    next_cycle();

    // Stall counter saturation on a very long miss
    reset_pulse();
    drive(1, 1, 0, 0, 0, 32'h700, 32'h0, 32'h0);
    next_cycle();
    repeat (65540) next_cycle();
    #2 check("sat_count", ex(1,0,32'h700,0,0, 0,0,1,0,0,16'hFFFF));
    dhit = 1'b1; dmemload = 32'h77;
    #1 check("sat_hit", ex(1,0,32'h700,0,32'h77, 1,0,0,0,0,16'hFFFF));
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("sat_after", ex(0,0,0,0,32'h77, 1,0,0,0,0,16'hFFFF));
    next_cycle();

    // Randomized traffic against the reference model
    reset_pulse();
    h_m = 0; p_m = 0; me_m = 0; cnt_m = 0; ld_m = '0;
    begin
      logic        v, r, w, h, hit, rst_now, op;
      logic [31:0] a, s, dl;
      obs_t        e;
      int          k;
      v = 0; r = 0; w = 0; h = 0; a = 0; s = 0;
      for (int c = 0; c < 3000; c++) begin
        rst_now = ($urandom_range(0, 99) == 0);
        if (!p_m) begin
          v = ($urandom_range(0, 3) != 0);
          k = $urandom_range(0, 9);
          r = (k <= 2) || (k == 6) || (k == 9);
          w = (k >= 3) && (k <= 6);
          h = ((k == 8) || (k == 9)) && ($urandom_range(0, 7) == 0);
          a = $urandom;
          if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
          s = $urandom;
        end
        hit = ($urandom_range(0, 2) == 0);
        dl  = $urandom;
        RST = rst_now;
        drive(v, r, w, h, hit, a, s, dl);

        e = '0;
        if (!rst_now) begin
          op    = v && (r || w);
          e.hl  = h_m;
          e.me  = me_m;
          e.cnt = (cnt_m > 65535) ? 16'hFFFF : 16'(cnt_m);
          e.ml  = ld_m;
          if (h_m) begin
            e.st = 1;
          end else if (!p_m && v && h) begin
            e.mw = 1;
            h_m  = 1;
          end else if (!p_m && op && (a % 4 != 0)) begin
            e.mrst = 1;
            me_m   = 1;
          end else if (p_m || op) begin
            e.ren = r;
            e.wen = w && !r;
            e.da  = a - (a % 4);
            e.ds  = s;
            if (p_m) cnt_m++;
            if (hit) begin
              e.mw = 1;
              e.ml = dl;
              if (p_m) ld_m = dl;
              p_m = 0;
            end else begin
              e.st = 1;
              p_m  = 1;
            end
          end else begin
            e.mw = 1;
          end
        end
        #2 check($sformatf("rand%0d", c), e);
        if (rst_now) begin
          h_m = 0; p_m = 0; me_m = 0; cnt_m = 0; ld_m = '0;
        end
        next_cycle();
        RST = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
